// File: rtl/gf_pkg.sv
// Shared constants and FSM state type for the GF(2^M) inverter.
// Default field: GF(2^7) with x^7+x+1; GF(2^8) AES polynomial provided for wider instances.
package gf_pkg;

  localparam int         GF7_M    = 7;
  localparam logic [7:0] GF7_POLY = 8'h83;
  localparam int         GF8_M    = 8;
  localparam logic [8:0] GF8_POLY = 9'h11B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } gf_state_e;

endpackage

// File: rtl/gf_halve.sv
// Division by x modulo POLY: g/x = g>>1 when g is even, else (g ^ POLY)>>1.
// Because POLY has bit 0 set, the XOR always makes the value even before the shift.
module gf_halve
  import gf_pkg::*;
#(
  parameter int         M    = GF7_M,
  parameter logic [M:0] POLY = GF7_POLY
) (
  input  logic [M:0] i_g,
  output logic [M:0] o_g
);

  logic [M:0] w_red;

  assign w_red = i_g[0] ? (i_g ^ POLY) : i_g;
  assign o_g   = {1'b0, w_red[M:1]};

endmodule

// File: rtl/gf_inverse_seq.sv
// Handshaked GF(2^M) inverter using the binary extended Euclidean algorithm, one step per clock.
// Optional out_err port (zero operand flag) is enabled by defining GF_INV_ZERO_ERR_EN.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand
// RUN   | one Euclid step per cycle on u, v, g1, g2
// DONE  | out_valid high, result held until out_ready
module gf_inverse_seq
  import gf_pkg::*;
#(
  parameter int         M    = GF7_M,
  parameter logic [M:0] POLY = GF7_POLY
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] in_a,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_b
`ifdef GF_INV_ZERO_ERR_EN
  ,
  output logic         out_err
`endif
);

  localparam logic [M:0] ONE = {{M{1'b0}}, 1'b1};

  gf_state_e  r_state, w_state_nxt;
  logic [M:0] r_u, r_v, r_g1, r_g2;
  logic [M:0] w_u_nxt, w_v_nxt, w_g1_nxt, w_g2_nxt;
  logic [M:0] w_g1_half, w_g2_half;
  logic [M-1:0] r_b, w_b_nxt;
  logic       r_valid, w_valid_nxt;
`ifdef GF_INV_ZERO_ERR_EN
  logic       r_err, w_err_nxt;
`endif

  gf_halve #(.M(M), .POLY(POLY)) u_halve_g1 (.i_g(r_g1), .o_g(w_g1_half));
  gf_halve #(.M(M), .POLY(POLY)) u_halve_g2 (.i_g(r_g2), .o_g(w_g2_half));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_u     <= '0;
      r_v     <= '0;
      r_g1    <= '0;
      r_g2    <= '0;
      r_b     <= '0;
      r_valid <= 1'b0;
`ifdef GF_INV_ZERO_ERR_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_u     <= w_u_nxt;
      r_v     <= w_v_nxt;
      r_g1    <= w_g1_nxt;
      r_g2    <= w_g2_nxt;
      r_b     <= w_b_nxt;
      r_valid <= w_valid_nxt;
`ifdef GF_INV_ZERO_ERR_EN
      r_err   <= w_err_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_u_nxt     = r_u;
    w_v_nxt     = r_v;
    w_g1_nxt    = r_g1;
    w_g2_nxt    = r_g2;
    w_b_nxt     = r_b;
    w_valid_nxt = r_valid;
`ifdef GF_INV_ZERO_ERR_EN
    w_err_nxt   = r_err;
`endif
    case (r_state)
      IDLE: begin
        if (in_valid) begin
`ifdef GF_INV_ZERO_ERR_EN
          w_err_nxt = (in_a == '0);
`endif
          if (in_a == '0) begin
            w_b_nxt     = '0;
            w_valid_nxt = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_u_nxt     = {1'b0, in_a};
            w_v_nxt     = POLY;
            w_g1_nxt    = ONE;
            w_g2_nxt    = '0;
            w_state_nxt = RUN;
          end
        end
      end
      RUN: begin
        // Invariants: g1*a = u and g2*a = v (mod POLY); whichever of u, v reaches 1 holds the inverse.
        if (r_u == ONE) begin
          w_b_nxt     = r_g1[M-1:0];
          w_valid_nxt = 1'b1;
          w_state_nxt = DONE;
        end else if (r_v == ONE) begin
          w_b_nxt     = r_g2[M-1:0];
          w_valid_nxt = 1'b1;
          w_state_nxt = DONE;
        end else if (!r_u[0]) begin
          w_u_nxt  = r_u >> 1;
          w_g1_nxt = w_g1_half;
        end else if (!r_v[0]) begin
          w_v_nxt  = r_v >> 1;
          w_g2_nxt = w_g2_half;
        end else if (r_u >= r_v) begin
          w_u_nxt  = r_u ^ r_v;
          w_g1_nxt = r_g1 ^ r_g2;
        end else begin
          w_v_nxt  = r_v ^ r_u;
          w_g2_nxt = r_g2 ^ r_g1;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_valid;
  assign out_b     = r_b;
`ifdef GF_INV_ZERO_ERR_EN
  assign out_err   = r_err;
`endif

endmodule

// File: tb/tb_gf_inverse_seq.sv
// Self-checking bench for gf_inverse_seq: brute-force field-inverse model plus directed literals.
// Handles builds with or without GF_INV_ZERO_ERR_EN.
module tb_gf_inverse_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [6:0] in_a, out_b;
  logic       i8_valid, o8_ready, o8_valid, out8_ready;
  logic [7:0] i8_a, o8_b;
`ifdef GF_INV_ZERO_ERR_EN
  logic       out_err, o8_err;
`endif

  gf_inverse_seq #(.M(7), .POLY(8'h83)) dut7 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
    .out_valid(out_valid), .out_ready(out_ready), .out_b(out_b)
`ifdef GF_INV_ZERO_ERR_EN
    , .out_err(out_err)
`endif
  );

  gf_inverse_seq #(.M(8), .POLY(9'h11B)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(i8_valid), .in_ready(o8_ready), .in_a(i8_a),
    .out_valid(o8_valid), .out_ready(out8_ready), .out_b(o8_b)
`ifdef GF_INV_ZERO_ERR_EN
    , .out_err(o8_err)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Carry-less multiply followed by reduction modulo poly.
  function automatic int gf_mul(input int a, input int b, input int m, input int poly);
    int p = 0;
    for (int i = 0; i < m; i++)
      if (((b >> i) & 1) == 1) p ^= (a << i);
    for (int d = 2 * m - 2; d >= m; d--)
      if (((p >> d) & 1) == 1) p ^= (poly << (d - m));
    return p;
  endfunction

  // Inverse by exhaustive search; zero maps to zero.
  function automatic int gf_inv(input int a, input int m, input int poly);
    if (a == 0) return 0;
    for (int b = 1; b < (1 << m); b++)
      if (gf_mul(a, b, m, poly) == 1) return b;
    return -1;
  endfunction

  // Scoreboard for the M=7 instance: operands accepted, awaiting their result.
  int q[$];
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      check("in_ready_vs_inflight", int'(in_ready), int'(q.size() == 0));
      if (out_valid) begin
        if (q.size() == 0) begin
          check("out_valid_without_op", 1, 0);
        end else begin
          check("out_b_model", int'(out_b), gf_inv(q[0], 7, 'h83));
`ifdef GF_INV_ZERO_ERR_EN
          check("out_err_model", int'(out_err), int'(q[0] == 0));
`endif
          if (out_ready) void'(q.pop_front());
        end
      end else if (in_valid && in_ready) begin
        q.push_back(int'(in_a));
      end
    end
  end

  // Latency = clock edges from the accepting edge (inclusive) to the edge that raises out_valid.
  task automatic do_op7(input logic [6:0] a, output logic [6:0] b, output int lat);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    in_valid = 1'b1;
    in_a     = a;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) check("out_valid_timeout", 0, 1);
    b = out_b;
    @(posedge clk); #1;
  endtask

  task automatic do_op8(input logic [7:0] a, output logic [7:0] b);
    int n = 0;
    i8_valid = 1'b1;
    i8_a     = a;
    @(posedge clk); #1;
    i8_valid = 1'b0;
    while (!o8_valid && n < 60) begin
      @(posedge clk); #1; n++;
    end
    if (!o8_valid) check("m8_out_valid_timeout", 0, 1);
    b = o8_b;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] b, b0;
    logic [7:0] b8;
    logic [7:0] vec8 [4];
    int lat;

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; out_ready = 1'b1;
    i8_valid = 1'b0; i8_a = '0; out8_ready = 1'b1;
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_b", int'(out_b), 0);
`ifdef GF_INV_ZERO_ERR_EN
    check("rst_out_err", int'(out_err), 0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Pin the model with hand-derived inverses.
    check("model_inv7_01", gf_inv(1, 7, 'h83), 'h01);
    check("model_inv7_02", gf_inv(2, 7, 'h83), 'h41);
    check("model_inv7_03", gf_inv(3, 7, 'h83), 'h7E);
    check("model_inv8_53", gf_inv('h53, 8, 'h11B), 'hCA);

    do_op7(7'h01, b, lat);
    check("a01_out_b", int'(b), 'h01);
    check("a01_latency", lat, 2);
    do_op7(7'h02, b, lat);
    check("a02_out_b", int'(b), 'h41);
    do_op7(7'h03, b, lat);
    check("a03_out_b", int'(b), 'h7E);

    do_op7(7'h00, b, lat);
    check("zero_out_b", int'(b), 0);
    check("zero_latency", lat, 1);

    for (int a = 1; a < 128; a++) begin
      do_op7(7'(a), b, lat);
      check("sweep_product_is_one", gf_mul(a, int'(b), 7, 'h83), 1);
      check("sweep_latency_le_29", int'(lat <= 29), 1);
    end

    // Backpressure: result held, in_ready low, new operand ignored.
    out_ready = 1'b0;
    do_op7(7'h05, b0, lat);
    check("bp_first_result", int'(b0), gf_inv(5, 7, 'h83));
    in_valid = 1'b1;
    in_a     = 7'h09;
    repeat (10) begin
      @(posedge clk); #1;
      check("bp_out_valid_held", int'(out_valid), 1);
      check("bp_out_b_stable", int'(out_b), int'(b0));
      check("bp_in_ready_low", int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", int'(out_valid), 0);
    check("bp_release_ready", int'(in_ready), 1);
    repeat (3) begin
      @(posedge clk); #1;
      check("bp_nothing_queued", int'(out_valid), 0);
    end

    // Reset while holding a result in DONE: out_valid drops without a clock edge.
    out_ready = 1'b0;
    do_op7(7'h03, b, lat);
    #2 rst_n = 1'b0;
    #1;
    check("rst_done_out_valid", int'(out_valid), 0);
    check("rst_done_in_ready", int'(in_ready), 1);
    check("rst_done_out_b", int'(out_b), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Reset mid-RUN, then a fresh operation.
    in_valid = 1'b1;
    in_a     = 7'h40;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_run_busy", int'(in_ready), 0);
    rst_n = 1'b0;
    #1;
    check("mid_run_rst_in_ready", int'(in_ready), 1);
    check("mid_run_rst_out_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op7(7'h03, b, lat);
    check("after_rst_a03", int'(b), 'h7E);

    // GF(2^8) instance with the AES polynomial.
    do_op8(8'h53, b8);
    check("m8_a53_literal", int'(b8), 'hCA);
    vec8[0] = 8'h01; vec8[1] = 8'h02; vec8[2] = 8'hFF; vec8[3] = 8'h80;
    for (int i = 0; i < 4; i++) begin
      do_op8(vec8[i], b8);
      check("m8_model", int'(b8), gf_inv(int'(vec8[i]), 8, 'h11B));
    end

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/gf_inverse_seq.md
# gf_inverse_seq

Parametrised, handshaked sequential inverter in GF(2^M) with a configurable irreducible polynomial. It computes a⁻¹ mod P(x) using the binary extended Euclidean algorithm, one step per clock, and serves the field-arithmetic datapath. It replaces the fixed 7-bit load-strobe inverter with a generic width, valid/ready flow control on both sides, and defined zero-input handling.

## Interface
Parameters:
- M, 7, field degree; operand/result width, M ≥ 2.
- POLY, 8'h83, irreducible polynomial, M+1 bits wide; bit M and bit 0 must be 1 (default is x^7+x+1).

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand offered.
- in_ready  out  1  block accepts an operand; high only in IDLE.
- in_a  in  M  operand a, polynomial basis, bit 0 = x^0.
- out_valid  out  1  result available; held until accepted.
- out_ready  in  1  consumer accepts the result.
- out_b  out  M  a⁻¹ mod POLY; 0 for a = 0.
- out_err  out  1  a was zero. Present only with GF_INV_ZERO_ERR_EN.

## Operation
- States: IDLE, RUN, DONE. Reset puts the FSM in IDLE, with in_ready=1, out_valid=0, out_b=0, out_err=0. Internal registers are cleared.
- Accept happens in IDLE when in_valid && in_ready:
  - If in_a == 0: set out_b=0 and out_err=1, then go to DONE.
  - Otherwise load u=in_a (zero-extended to M+1 bits), v=POLY, g1=1, g2=0, then go to RUN.
- Each RUN cycle performs exactly one action, evaluated in this priority order:
  1. If u == 1: out_b = g1[M-1:0], go to DONE.
  2. Else if v == 1: out_b = g2[M-1:0], go to DONE.
  3. Else if u[0] == 0: u = u>>1; g1 = halve(g1).
  4. Else if v[0] == 0: v = v>>1; g2 = halve(g2).
  5. Else if u ≥ v (unsigned): u ^= v; g1 ^= g2.
  6. Else: v ^= u; g2 ^= g1.
- halve(g) = g>>1 if g[0]==0, else (g ^ POLY)>>1. The result always fits in M bits.
- u, v, g1, g2 are all M+1 bits. No carries; all addition is XOR.
- DONE holds out_valid=1 with out_b and out_err stable. When out_ready is high, go to IDLE; out_valid deasserts on the next cycle. out_err clears on the next accept.
- in_valid is ignored outside IDLE. No operand is queued.
- Any rst_n assertion, including mid-RUN or in DONE, aborts immediately. The in-flight result is discarded and out_valid drops asynchronously.

## Timing
- Accept at edge T:
  - Zero operand: out_valid is high after edge T+1.
  - Nonzero operand: first RUN cycle is T+1. out_valid rises one cycle after the terminating RUN cycle.
- Latency is data-dependent and bounded. deg u + deg v ≤ 2M−1 at start, and every XOR step is followed by a shift. Therefore total latency from accept to out_valid is ≤ 4M+1 cycles (29 for M=7).
- a=1 takes exactly 2 cycles from accept to out_valid.
- Throughput: one operation in flight. in_ready reasserts the cycle after the output handshake.
- out_valid and out_b are registered outputs.

## Configuration
- GF_INV_ZERO_ERR_EN:
  - Defined: out_err port exists and pulses with the zero-operand result as described above.
  - Undefined: port is absent. A zero operand still completes in 1 cycle with out_b=0, giving no indication.

## Structure
- Package gf_pkg holds:
  - default M and POLY constants (GF7_POLY=8'h83, GF8_POLY=9'h11B);
  - the FSM state enum (IDLE/RUN/DONE).
- One combinational sub-module, gf_halve (M, POLY). Two instances are used, one for g1 and one for g2.

## Test plan
- M=7, POLY=8'h83 (defaults for the first three items):
  - in_a=7'h01 → out_b=7'h01, out_valid exactly 2 cycles after accept.
  - in_a=7'h02 → out_b=7'h41; in_a=7'h03 → out_b=7'h7E.
  - Exhaustive sweep over all 127 nonzero a, out_ready held high → (a·b mod POLY)==1 for each, and latency ≤ 29 cycles.
- in_a=0 → out_b=0, out_valid after 1 cycle, out_err=1 with GF_INV_ZERO_ERR_EN defined.
- Backpressure: hold out_ready=0 for 10 cycles → out_valid and out_b stable, in_ready=0, a new in_valid is not accepted. Raising out_ready completes the transfer.
- Reset mid-RUN: pulse rst_n low → out_valid=0, in_ready=1. A following operand 7'h03 returns 7'h7E.
- M=8, POLY=9'h11B → in_a=8'h53 gives out_b=8'hCA.
